regfile_mp_dump: RTL

- Parametrised successor to the CPU integer register file.
- Width and depth are configurable. Register 0 is optionally hardwired to zero.
- Two combinational read ports and one synchronous write port.
- A registered monitor output, plus a valid/ready dump sequencer that streams every register to a debug or trace sink without stalling the datapath.

---
 rtl/regfile_pkg.sv | 13 +
 rtl/regfile_dump_seq.sv | 74 +++++++
 rtl/regfile_mp_dump.sv | 79 +++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// Shared types and defaults for the multi-port register file with dump sequencer.
package regfile_pkg;

  typedef enum logic {IDLE, STREAM} dump_state_t;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;

  function automatic int depth_of(input int addr_w);
    return 1 << addr_w;
  endfunction

endpackage

// File: rtl/regfile_dump_seq.sv
// Dump sequencer: walks every register index and presents a snapshot of each
// value on a valid/ready stream.
module regfile_dump_seq
  import regfile_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              start,
  input  logic              ready,
  output logic [ADDR_W-1:0] rd_idx,
  input  logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              valid,
  output logic [ADDR_W-1:0] index,
  output logic [DATA_W-1:0] data,
  output logic              last
);

  dump_state_t       state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [DATA_W-1:0] data_q, data_d;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
    end
  end

  // rd_data is the post-edge value of rd_idx, so a write landing on the
  // capture edge is included in the snapshot.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    data_d  = data_q;
    rd_idx  = idx_q + ADDR_W'(1);
    case (state_q)
      IDLE: begin
        rd_idx = '0;
        if (start) begin
          state_d = STREAM;
          idx_d   = '0;
          data_d  = rd_data;
        end
      end
      STREAM: begin
        if (ready) begin
          if (idx_q == '1) begin
            state_d = IDLE;
          end else begin
            idx_d  = idx_q + ADDR_W'(1);
            data_d = rd_data;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign valid = (state_q == STREAM);
  assign busy  = valid;
  assign last  = valid && (idx_q == '1);
  assign index = idx_q;
  assign data  = data_q;

endmodule

// File: rtl/regfile_mp_dump.sv
// Parametrised register file: 2 comb read ports, 1 write port, monitor output
// and a non-stalling dump stream. Same-cycle write bypass: REGFILE_BYPASS_EN.
module regfile_mp_dump
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int ZERO_REG = 1,
  parameter int MON_REG  = 1
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Reg_Write,
  input  logic [ADDR_W-1:0] Write_Register,
  input  logic [DATA_W-1:0] Write_Data,
  input  logic [ADDR_W-1:0] Read_Register1,
  input  logic [ADDR_W-1:0] Read_Register2,
  output logic [DATA_W-1:0] Read_Data1,
  output logic [DATA_W-1:0] Read_Data2,
  output logic [DATA_W-1:0] Register_Out,
  input  logic              Dump_Start,
  output logic              Dump_Busy,
  output logic              Dump_Valid,
  input  logic              Dump_Ready,
  output logic [ADDR_W-1:0] Dump_Index,
  output logic [DATA_W-1:0] Dump_Data,
  output logic              Dump_Last
);

  localparam int                DEPTH   = depth_of(ADDR_W);
  localparam logic [ADDR_W-1:0] MON_IDX = ADDR_W'(MON_REG);

  logic [DEPTH-1:0][DATA_W-1:0] regs, regs_nxt;
  logic [ADDR_W-1:0]            seq_rd_idx;

  // regs_nxt is the value each register holds after the coming edge. With
  // ZERO_REG, entry 0 is never written so it stays at its reset value of 0.
  for (genvar i = 0; i < DEPTH; i++) begin : g_nxt
    localparam bit WR_OK = !(ZERO_REG != 0 && i == 0);
    assign regs_nxt[i] = (WR_OK && Reg_Write && Write_Register == ADDR_W'(i))
                         ? Write_Data : regs[i];
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      regs         <= '0;
      Register_Out <= '0;
    end else begin
      regs         <= regs_nxt;
      Register_Out <= regs_nxt[MON_IDX];
    end
  end

`ifdef REGFILE_BYPASS_EN
  assign Read_Data1 = regs_nxt[Read_Register1];
  assign Read_Data2 = regs_nxt[Read_Register2];
`else
  assign Read_Data1 = regs[Read_Register1];
  assign Read_Data2 = regs[Read_Register2];
`endif

  regfile_dump_seq #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_seq (
    .Clock   (Clock),
    .Reset   (Reset),
    .start   (Dump_Start),
    .ready   (Dump_Ready),
    .rd_idx  (seq_rd_idx),
    .rd_data (regs_nxt[seq_rd_idx]),
    .busy    (Dump_Busy),
    .valid   (Dump_Valid),
    .index   (Dump_Index),
    .data    (Dump_Data),
    .last    (Dump_Last)
  );

endmodule
